frame_sender_param: RTL and testbench

Parametrised successor to the single-shot test-frame sender for the delay tester. It generates bursts of Ethernet frames toward the MAC TX byte interface. Each frame carries a configurable header, a 32-bit sequence number and a selectable payload pattern, with a programmable inter-frame gap and frame count. It sits between the test controller (start/stop/config) and the MAC TX client port. The MAC appends CRC.

---
 rtl/frame_sender_param.sv | 244 ++++++++++++++++++++++++
 tb/tb_frame_sender_param.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_sender_param.sv
// frame_sender_param: burst generator of Ethernet test frames toward a MAC TX
// byte interface. Each frame carries DST/SRC/EtherType, a 32-bit sequence
// number and a zero or incrementing payload; the MAC appends the CRC.
// Optional build macro TX_TIMESTAMP_EN inserts a 4-byte tx_clk timestamp,
// captured on the ack cycle, between the sequence field and the payload.
module frame_sender_param #(
    parameter logic [47:0] MAC_SRC_ADDR = 48'h004e46324300,
    parameter logic [47:0] MAC_DST_ADDR = 48'h004e46324301,
    parameter logic [15:0] ETH_TYPE     = 16'h88B5,
    parameter int          LEN_W        = 14,
    parameter int          GAP_W        = 16,
    parameter int          CNT_W        = 16
) (
    input  logic             tx_clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] num_frames,
    input  logic [LEN_W-1:0] payload_len,
    input  logic [GAP_W-1:0] gap_cycles,
    input  logic             pattern_sel,
    output logic             conf_tx_en,
    output logic             conf_tx_jumbo_en,
    output logic             conf_tx_no_gen_crc,
    output logic [7:0]       mac_tx_data,
    output logic             mac_tx_dvld,
    input  logic             mac_tx_ack,
    output logic             busy,
    output logic [CNT_W-1:0] frames_sent
);

`ifdef TX_TIMESTAMP_EN
    // Timestamp field takes 4 bytes, so the payload floor drops to keep 60 bytes.
    localparam int MIN_PAYLOAD = 38;
`else
    localparam int MIN_PAYLOAD = 42;
`endif

    localparam logic [LEN_W-1:0] MIN_LEN     = LEN_W'(MIN_PAYLOAD);
    // Jumbo when payload + 18 header/seq/CRC-less overhead exceeds 1500.
    localparam logic [LEN_W:0]   JUMBO_LIMIT = (LEN_W+1)'(1500 - 18);
    localparam logic [LEN_W:0]   BYTE_ONE    = (LEN_W+1)'(1);
    localparam logic [GAP_W-1:0] GAP_ONE     = GAP_W'(1);
    localparam logic [CNT_W-1:0] FRM_ONE     = CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_GAP,
        S_WAIT_ACK,
        S_DST,
        S_SRC,
        S_TYPE,
        S_SEQ,
        S_TS,
        S_PAYLOAD
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [LEN_W:0]   r_cnt;
    logic [LEN_W:0]   w_next_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [31:0]      r_seq;
    logic [CNT_W-1:0] r_frames_sent;
    logic [CNT_W-1:0] w_frames_inc;
    logic [CNT_W-1:0] r_num;
    logic [LEN_W-1:0] r_eff_len;
    logic [LEN_W-1:0] w_eff_len;
    logic [GAP_W-1:0] r_gap;
    logic             r_pattern;
    logic             r_stop_seen;
    logic             r_busy;
    logic             r_tx_en;
    logic             r_jumbo;
    logic [7:0]       r_data;
    logic             r_dvld;
    logic [7:0]       w_next_data;
    logic             w_start_run;
    logic             w_frame_end;
    logic             w_run_done;
    logic             w_in_frame;
`ifdef TX_TIMESTAMP_EN
    logic [31:0]      r_ts_free;
    logic [31:0]      r_ts_cap;
`endif

    // Byte of a 48-bit address, index 0 = most significant byte.
    function automatic logic [7:0] sel_byte48(input logic [47:0] v, input logic [2:0] idx);
        case (idx)
            3'd0:    sel_byte48 = v[47:40];
            3'd1:    sel_byte48 = v[39:32];
            3'd2:    sel_byte48 = v[31:24];
            3'd3:    sel_byte48 = v[23:16];
            3'd4:    sel_byte48 = v[15:8];
            3'd5:    sel_byte48 = v[7:0];
            default: sel_byte48 = 8'h00;
        endcase
    endfunction

    // Byte of a 32-bit word, index 0 = most significant byte.
    function automatic logic [7:0] sel_byte32(input logic [31:0] v, input logic [1:0] idx);
        case (idx)
            2'd0:    sel_byte32 = v[31:24];
            2'd1:    sel_byte32 = v[23:16];
            2'd2:    sel_byte32 = v[15:8];
            default: sel_byte32 = v[7:0];
        endcase
    endfunction

    function automatic logic cnt_is(input logic [LEN_W:0] c, input int n);
        cnt_is = (c == (LEN_W+1)'(n));
    endfunction

    assign w_eff_len    = (payload_len < MIN_LEN) ? MIN_LEN : payload_len;
    assign w_frames_inc = (r_frames_sent == '1) ? r_frames_sent : r_frames_sent + FRM_ONE;
    assign w_start_run  = (r_state == S_IDLE) && start && !stop;
    assign w_run_done   = r_stop_seen || stop || ((r_num != '0) && (w_frames_inc == r_num));
    assign w_in_frame   = (r_state == S_DST) || (r_state == S_SRC) || (r_state == S_TYPE) ||
                          (r_state == S_SEQ) || (r_state == S_TS)  || (r_state == S_PAYLOAD);

    // Next-state logic: sequences the frame fields and the inter-frame gap.
    always_comb begin
        w_next_state = r_state;
        w_frame_end  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_run) w_next_state = S_GAP;
            end
            S_GAP: begin
                if (stop)                             w_next_state = S_IDLE;
                else if ((r_gap_cnt + GAP_ONE) >= r_gap) w_next_state = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                if (stop)            w_next_state = S_IDLE;
                else if (mac_tx_ack) w_next_state = S_DST;
            end
            S_DST:  if (cnt_is(r_cnt, 4)) w_next_state = S_SRC;
            S_SRC:  if (cnt_is(r_cnt, 5)) w_next_state = S_TYPE;
            S_TYPE: if (cnt_is(r_cnt, 1)) w_next_state = S_SEQ;
            S_SEQ: begin
`ifdef TX_TIMESTAMP_EN
                if (cnt_is(r_cnt, 3)) w_next_state = S_TS;
`else
                if (cnt_is(r_cnt, 3)) w_next_state = S_PAYLOAD;
`endif
            end
            S_TS:   if (cnt_is(r_cnt, 3)) w_next_state = S_PAYLOAD;
            S_PAYLOAD: begin
                if ((r_cnt + BYTE_ONE) == {1'b0, r_eff_len}) begin
                    w_frame_end  = 1'b1;
                    w_next_state = w_run_done ? S_IDLE : S_GAP;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Byte counter restarts on every state change; byte mux looks one cycle ahead
    // so the registered outputs line up with the state they belong to.
    always_comb begin
        w_next_cnt  = (w_next_state != r_state) ? '0 : (r_cnt + BYTE_ONE);
        w_next_data = 8'h00;
        case (w_next_state)
            S_WAIT_ACK: w_next_data = MAC_DST_ADDR[47:40];
            S_DST:      w_next_data = sel_byte48(MAC_DST_ADDR, w_next_cnt[2:0] + 3'd1);
            S_SRC:      w_next_data = sel_byte48(MAC_SRC_ADDR, w_next_cnt[2:0]);
            S_TYPE:     w_next_data = w_next_cnt[0] ? ETH_TYPE[7:0] : ETH_TYPE[15:8];
            S_SEQ:      w_next_data = sel_byte32(r_seq, w_next_cnt[1:0]);
`ifdef TX_TIMESTAMP_EN
            S_TS:       w_next_data = sel_byte32(r_ts_cap, w_next_cnt[1:0]);
`endif
            S_PAYLOAD:  w_next_data = r_pattern ? w_next_cnt[7:0] : 8'h00;
            default:    w_next_data = 8'h00;
        endcase
    end

    // State, counters, run bookkeeping and registered MAC outputs.
    always_ff @(posedge tx_clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_gap_cnt     <= '0;
            r_seq         <= '0;
            r_frames_sent <= '0;
            r_num         <= '0;
            r_eff_len     <= '0;
            r_gap         <= '0;
            r_pattern     <= 1'b0;
            r_stop_seen   <= 1'b0;
            r_busy        <= 1'b0;
            r_tx_en       <= 1'b0;
            r_jumbo       <= 1'b0;
            r_data        <= 8'h00;
            r_dvld        <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_cnt     <= w_next_cnt;
            r_gap_cnt <= (r_state == S_GAP) ? (r_gap_cnt + GAP_ONE) : '0;
            r_tx_en   <= 1'b1;
            r_busy    <= (w_next_state != S_IDLE);
            r_data    <= w_next_data;
            r_dvld    <= (w_next_state inside {S_WAIT_ACK, S_DST, S_SRC, S_TYPE,
                                               S_SEQ, S_TS, S_PAYLOAD});
            if (w_start_run) begin
                r_num         <= num_frames;
                r_eff_len     <= w_eff_len;
                r_gap         <= gap_cycles;
                r_pattern     <= pattern_sel;
                r_jumbo       <= ({1'b0, w_eff_len} > JUMBO_LIMIT);
                r_seq         <= '0;
                r_frames_sent <= '0;
                r_stop_seen   <= 1'b0;
            end else begin
                if (stop && w_in_frame) r_stop_seen <= 1'b1;
                if (w_frame_end) begin
                    r_seq         <= r_seq + 32'd1;
                    r_frames_sent <= w_frames_inc;
                end
            end
        end
    end

`ifdef TX_TIMESTAMP_EN
    // Free-running cycle counter, sampled when the MAC takes the first byte.
    always_ff @(posedge tx_clk or negedge reset) begin
        if (!reset) begin
            r_ts_free <= '0;
            r_ts_cap  <= '0;
        end else begin
            r_ts_free <= r_ts_free + 32'd1;
            if ((r_state == S_WAIT_ACK) && (w_next_state == S_DST)) r_ts_cap <= r_ts_free;
        end
    end
`endif

    assign conf_tx_en         = r_tx_en;
    assign conf_tx_jumbo_en   = r_jumbo;
    assign conf_tx_no_gen_crc = 1'b0;
    assign mac_tx_data        = r_data;
    assign mac_tx_dvld        = r_dvld;
    assign busy               = r_busy;
    assign frames_sent        = r_frames_sent;

endmodule

// File: tb/tb_frame_sender_param.sv
// Testbench for frame_sender_param: directed runs with randomized lengths,
// gaps, patterns and ack latency, checked against a byte-level frame model.
module tb_frame_sender_param;
    localparam int LEN_W = 14;
    localparam int GAP_W = 16;
    localparam int CNT_W = 16;
    localparam logic [47:0] SRC = 48'h004e46324300;
    localparam logic [47:0] DST = 48'h004e46324301;
`ifdef TX_TIMESTAMP_EN
    localparam int MIN_LEN = 38;
    localparam int TS_B    = 4;
`else
    localparam int MIN_LEN = 42;
    localparam int TS_B    = 0;
`endif

    logic             tx_clk = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [CNT_W-1:0] num_frames = '0;
    logic [LEN_W-1:0] payload_len = '0;
    logic [GAP_W-1:0] gap_cycles = '0;
    logic             pattern_sel = 1'b0;
    logic             conf_tx_en;
    logic             conf_tx_jumbo_en;
    logic             conf_tx_no_gen_crc;
    logic [7:0]       mac_tx_data;
    logic             mac_tx_dvld;
    logic             mac_tx_ack = 1'b0;
    logic             busy;
    logic [CNT_W-1:0] frames_sent;

    always #5 tx_clk = ~tx_clk;

    frame_sender_param dut (
        .tx_clk(tx_clk), .reset(reset), .start(start), .stop(stop),
        .num_frames(num_frames), .payload_len(payload_len), .gap_cycles(gap_cycles),
        .pattern_sel(pattern_sel), .conf_tx_en(conf_tx_en),
        .conf_tx_jumbo_en(conf_tx_jumbo_en), .conf_tx_no_gen_crc(conf_tx_no_gen_crc),
        .mac_tx_data(mac_tx_data), .mac_tx_dvld(mac_tx_dvld), .mac_tx_ack(mac_tx_ack),
        .busy(busy), .frames_sent(frames_sent)
    );

    int tests = 0;
    int fails = 0;

    // MAC-side ack responder state
    int ack_delay = 0;
    bit ack_sent = 0;
    int wait_cnt = 0;

    // Capture state
    logic [7:0] cap_data[$];
    int         cap_start[$];
    int         cap_len[$];
    int         cap_ack_cyc[$];
    int         gaps[$];
    logic [7:0] cur_q[$];
    logic [7:0] exp_q[$];
    bit         in_frame = 0;
    bit         have_prev = 0;
    bit         prev_dvld = 0;
    int         idle_run = 0;
    int         bad_idle = 0;
    int         bad_wait = 0;
    int         dvld_cycles = 0;
    int         cyc = 0;

    // Ack responder: acks the first byte ack_delay cycles after dvld rises.
    initial begin
        forever begin
            @(posedge tx_clk); #1;
            if (mac_tx_dvld && !ack_sent) begin
                if (wait_cnt >= ack_delay) begin
                    mac_tx_ack = 1'b1;
                    ack_sent = 1;
                end else begin
                    wait_cnt++;
                end
            end else begin
                mac_tx_ack = 1'b0;
            end
            if (!mac_tx_dvld) begin
                ack_sent = 0;
                wait_cnt = 0;
            end
        end
    end

    // Frame monitor, sampled on the falling edge.
    always @(negedge tx_clk) begin
        cyc++;
        if (mac_tx_dvld) begin
            dvld_cycles++;
            if (!prev_dvld && have_prev) gaps.push_back(idle_run);
            if (in_frame) begin
                cur_q.push_back(mac_tx_data);
            end else if (mac_tx_ack) begin
                in_frame = 1;
                cur_q.push_back(mac_tx_data);
                cap_ack_cyc.push_back(cyc);
            end else if (mac_tx_data !== DST[47:40]) begin
                bad_wait++;
            end
            idle_run = 0;
        end else begin
            if (mac_tx_data !== 8'h00) bad_idle++;
            if (in_frame) begin
                cap_start.push_back(cap_data.size());
                cap_len.push_back(cur_q.size());
                foreach (cur_q[i]) cap_data.push_back(cur_q[i]);
                cur_q.delete();
                in_frame = 0;
                have_prev = 1;
            end
            idle_run++;
        end
        prev_dvld = mac_tx_dvld;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge tx_clk); #1;
    endtask

    task automatic clear_cap();
        cap_data.delete(); cap_start.delete(); cap_len.delete();
        cap_ack_cyc.delete(); gaps.delete(); cur_q.delete();
        have_prev = 0; bad_idle = 0; bad_wait = 0; dvld_cycles = 0;
    endtask

    task automatic run(input int n, input int len, input int gap, input bit pat);
        num_frames  = CNT_W'(n);
        payload_len = LEN_W'(len);
        gap_cycles  = GAP_W'(gap);
        pattern_sel = pat;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (busy === 1'b1 && k < budget) begin
            @(negedge tx_clk);
            k++;
        end
        check({tag, "_idle"}, busy, 1'b0);
        @(negedge tx_clk);
        @(negedge tx_clk);
    endtask

    function automatic int eff_len(input int len);
        return (len < MIN_LEN) ? MIN_LEN : len;
    endfunction

    // Reference frame: DST, SRC, EtherType, seq, [timestamp], payload.
    task automatic build_exp(input int seq, input int len, input bit pat);
        logic [47:0] d;
        logic [47:0] s;
        logic [31:0] q;
        logic [31:0] nn;
        d = DST; s = SRC; q = seq;
        exp_q.delete();
        for (int b = 0; b < 6; b++) exp_q.push_back(d[47-8*b -: 8]);
        for (int b = 0; b < 6; b++) exp_q.push_back(s[47-8*b -: 8]);
        exp_q.push_back(8'h88);
        exp_q.push_back(8'hb5);
        for (int b = 0; b < 4; b++) exp_q.push_back(q[31-8*b -: 8]);
        for (int b = 0; b < TS_B; b++) exp_q.push_back(8'h00);
        for (int n = 0; n < eff_len(len); n++) begin
            nn = n;
            exp_q.push_back(pat ? nn[7:0] : 8'h00);
        end
    endtask

    task automatic check_frame(input string tag, input int idx, input int seq,
                               input int len, input bit pat);
        int bad;
        int first_bad;
        int base;
        check({tag, "_present"}, (cap_len.size() > idx), 1'b1);
        if (cap_len.size() > idx) begin
            build_exp(seq, len, pat);
            check({tag, "_len"}, cap_len[idx], exp_q.size());
            bad = 0;
            first_bad = -1;
            base = cap_start[idx];
            for (int i = 0; i < exp_q.size() && i < cap_len[idx]; i++) begin
                if (i >= 18 && i < 18 + TS_B) continue;
                if (cap_data[base+i] !== exp_q[i]) begin
                    bad++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            if (bad != 0)
                $display("  %s first differing byte at %0d: got %0h want %0h", tag, first_bad,
                         cap_data[base+first_bad], exp_q[first_bad]);
            check({tag, "_bytes_bad"}, bad, 0);
        end
    endtask

    initial begin
        int len;
        int gap;
        int n;
        int k;
        int snap;
        bit pat;

        // Reset state
        repeat (3) tick();
        check("rst_dvld", mac_tx_dvld, 1'b0);
        check("rst_data", mac_tx_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_frames_sent", frames_sent, '0);
        check("rst_tx_en", conf_tx_en, 1'b0);
        check("rst_jumbo", conf_tx_jumbo_en, 1'b0);
        check("rst_no_gen_crc", conf_tx_no_gen_crc, 1'b0);
        @(posedge tx_clk); #1;
        reset = 1'b1;
        check("tx_en_at_release", conf_tx_en, 1'b0);
        tick();
        check("tx_en_after_clk", conf_tx_en, 1'b1);
        check("no_gen_crc_run", conf_tx_no_gen_crc, 1'b0);

        // Header/seq frame, ack 3 cycles after dvld
        clear_cap();
        ack_delay = 3;
        run(1, 46, 0, 1);
        wait_idle("hdr", 2000);
        check_frame("hdr", 0, 0, 46, 1);
        check("hdr_dvld_cycles", dvld_cycles, 3 + 18 + TS_B + eff_len(46));
        check("hdr_frames_sent", frames_sent, 1);
        check("hdr_jumbo", conf_tx_jumbo_en, 1'b0);
        check("hdr_wait_data", bad_wait, 0);
        check("hdr_idle_data", bad_idle, 0);

        // Three-frame run with gap 10
        clear_cap();
        ack_delay = $urandom_range(0, 4);
        pat = 1'($urandom_range(0, 1));
        run(3, 100, 10, pat);
        wait_idle("run3", 5000);
        for (int i = 0; i < 3; i++) check_frame($sformatf("run3_f%0d", i), i, i, 100, pat);
        check("run3_gap_count", gaps.size(), 2);
        if (gaps.size() >= 2) begin
            check("run3_gap0", gaps[0], 10);
            check("run3_gap1", gaps[1], 10);
        end
        check("run3_frames_sent", frames_sent, 3);

        // Clamp to minimum and jumbo
        clear_cap();
        ack_delay = 0;
        run(1, 5, 0, 1);
        wait_idle("clamp", 2000);
        check_frame("clamp", 0, 0, 5, 1);
        check("clamp_jumbo", conf_tx_jumbo_en, 1'b0);
        clear_cap();
        pat = 1'($urandom_range(0, 1));
        run(1, 1600, 0, pat);
        check("jumbo_en", conf_tx_jumbo_en, 1'b1);
        wait_idle("jumbo", 4000);
        check_frame("jumbo", 0, 0, 1600, pat);

        // Randomized runs
        for (int r = 0; r < 3; r++) begin
            clear_cap();
            n   = $urandom_range(1, 2);
            len = $urandom_range(0, 120);
            gap = $urandom_range(0, 15);
            pat = 1'($urandom_range(0, 1));
            ack_delay = $urandom_range(0, 5);
            run(n, len, gap, pat);
            wait_idle($sformatf("rnd%0d", r), 3000);
            for (int i = 0; i < n; i++) check_frame($sformatf("rnd%0d_f%0d", r, i), i, i, len, pat);
            check($sformatf("rnd%0d_frames_sent", r), frames_sent, n);
            check($sformatf("rnd%0d_jumbo", r), conf_tx_jumbo_en, (eff_len(len) + 18 > 1500));
            if (n == 2 && gaps.size() == 1)
                check($sformatf("rnd%0d_gap", r), gaps[0], (gap == 0) ? 1 : gap);
        end

        // Continuous run stopped mid-payload of frame 4
        clear_cap();
        ack_delay = 1;
        run(0, 60, 2, 1);
        k = 0;
        while (!(cap_len.size() >= 3 && cur_q.size() >= 30) && k < 3000) begin
            @(negedge tx_clk);
            k++;
        end
        check("cont_reached_f4", (k < 3000), 1'b1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle("cont", 2000);
        check("cont_frames", cap_len.size(), 4);
        for (int i = 0; i < 4; i++) check_frame($sformatf("cont_f%0d", i), i, i, 60, 1);
        check("cont_frames_sent", frames_sent, 4);

        // Stop during the gap
        clear_cap();
        run(0, 42, 30, 0);
        k = 0;
        while (cap_len.size() < 1 && k < 2000) begin
            @(negedge tx_clk);
            k++;
        end
        check("gapstop_reached", (k < 2000), 1'b1);
        repeat (5) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        snap = dvld_cycles;
        repeat (60) tick();
        check("gapstop_no_dvld", dvld_cycles, snap);
        check("gapstop_busy", busy, 1'b0);
        check("gapstop_frames_sent", frames_sent, 1);

        // start and stop together while idle: stop wins
        start = 1'b1;
        stop = 1'b1;
        tick();
        start = 1'b0;
        stop = 1'b0;
        repeat (3) tick();
        check("startstop_busy", busy, 1'b0);
        check("startstop_frames_sent", frames_sent, 1);
        check("startstop_no_dvld", dvld_cycles, snap);

        // Reset in the middle of a frame
        clear_cap();
        ack_delay = 1;
        run(1, 100, 0, 1);
        k = 0;
        while (cur_q.size() < 20 && k < 2000) begin
            @(negedge tx_clk);
            k++;
        end
        check("rstmid_reached", (k < 2000), 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check("rstmid_dvld_async", mac_tx_dvld, 1'b0);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_tx_en", conf_tx_en, 1'b0);
        repeat (2) @(negedge tx_clk);
        @(posedge tx_clk); #1;
        reset = 1'b1;
        check("rstmid_tx_en_release", conf_tx_en, 1'b0);
        tick();
        check("rstmid_tx_en_after", conf_tx_en, 1'b1);
        repeat (2) tick();
        clear_cap();
        run(1, 50, 0, 0);
        wait_idle("rstmid_next", 2000);
        check_frame("rstmid_next", 0, 0, 50, 0);
        check("rstmid_frames_sent", frames_sent, 1);

`ifdef TX_TIMESTAMP_EN
        // Timestamp delta matches ack spacing
        clear_cap();
        ack_delay = $urandom_range(0, 4);
        run(2, 42, 50, 1);
        wait_idle("ts", 3000);
        check("ts_frames", cap_len.size(), 2);
        if (cap_len.size() >= 2) begin
            logic [31:0] t0;
            logic [31:0] t1;
            t0 = '0;
            t1 = '0;
            for (int b = 0; b < 4; b++) begin
                t0 = {t0[23:0], cap_data[cap_start[0] + 18 + b]};
                t1 = {t1[23:0], cap_data[cap_start[1] + 18 + b]};
            end
            check("ts_delta", t1 - t0, 32'(cap_ack_cyc[1] - cap_ack_cyc[0]));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
